// File: rtl/des_sel_pkg.sv
// Shared types and frame layout for the design-select serial loader.
package des_sel_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      CHECK  = 2'd2,
      SWITCH = 2'd3
   } loader_state_t;

   localparam logic [3:0] CFG_MAGIC      = 4'hA;
   localparam int         CFG_FRAME_BITS = 16;

   localparam int MAGIC_MSB = 15;
   localparam int MAGIC_LSB = 12;
   localparam int HOLD_BIT  = 11;
   localparam int SYNC_BIT  = 10;
   localparam int SEL_MSB   = 9;
   localparam int SEL_LSB   = 4;
   localparam int CSUM_MSB  = 3;
   localparam int CSUM_LSB  = 0;

   // Bit counter saturates here so over-long frames stay distinguishable.
   localparam logic [4:0] CNT_OVF = 5'd17;

   function automatic logic frame_valid(input logic [CFG_FRAME_BITS-1:0] f,
                                        input logic [4:0] n);
      logic [3:0] csum;
      csum = f[15:12] ^ f[11:8] ^ f[7:4];
      return (n == 5'(CFG_FRAME_BITS)) &&
             (f[MAGIC_MSB:MAGIC_LSB] == CFG_MAGIC) &&
             (f[CSUM_MSB:CSUM_LSB] == csum);
   endfunction

endpackage

// File: rtl/pin_sync.sv
// Two-flop synchronizer for an asynchronous pin, plus a history flop for edge detection.
module pin_sync #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic pin_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic sync1_q, sync2_q, sync3_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q <= RST_VAL;
         sync2_q <= RST_VAL;
         sync3_q <= RST_VAL;
      end else begin
         sync1_q <= pin_i;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   assign level_o = sync2_q;
   assign rise_o  = sync2_q & ~sync3_q;
   assign fall_o  = ~sync2_q & sync3_q;

endmodule

// File: rtl/des_sel_loader.sv
// Serial config front-end: receives csn-framed 16-bit frames, validates them and
// commits design-select controls, then holds a quiesce reset for SWITCH_HOLD cycles.
//
// state  | meaning
// IDLE   | waiting for a csn falling edge
// SHIFT  | shifting bits on sclk rising edges until csn rises
// CHECK  | one cycle: validate count, magic and checksum
// SWITCH | switch_reset high, hold counter running down
module des_sel_loader
   import des_sel_pkg::*;
#(
   parameter int SEL_W       = 6,
   parameter int SWITCH_HOLD = 16,
   parameter int RESET_SEL   = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cfg_csn_in,
   input  logic             cfg_sclk_in,
   input  logic             cfg_sdata_in,
   output logic [SEL_W-1:0] des_sel,
   output logic             hold_if_not_sel,
   output logic             sync_inputs,
   output logic             switch_reset,
   output logic             cfg_ok,
   output logic             cfg_err,
   output logic             busy
);

   logic csn_lvl, csn_rise, csn_fall;
   logic sclk_lvl, sclk_rise, sclk_fall;
   logic sdat_lvl, sdat_rise, sdat_fall;
   logic unused_sync;

   pin_sync #(.RST_VAL(1'b1)) u_csn (
      .clock(clock), .reset(reset), .pin_i(cfg_csn_in),
      .level_o(csn_lvl), .rise_o(csn_rise), .fall_o(csn_fall)
   );

   pin_sync #(.RST_VAL(1'b0)) u_sclk (
      .clock(clock), .reset(reset), .pin_i(cfg_sclk_in),
      .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
   );

   pin_sync #(.RST_VAL(1'b0)) u_sdata (
      .clock(clock), .reset(reset), .pin_i(cfg_sdata_in),
      .level_o(sdat_lvl), .rise_o(sdat_rise), .fall_o(sdat_fall)
   );

   assign unused_sync = ^{csn_lvl, sclk_lvl, sclk_fall, sdat_rise, sdat_fall};

   localparam logic [7:0] HOLD_INIT = 8'(SWITCH_HOLD);

   loader_state_t             state_q, state_d;
   logic [CFG_FRAME_BITS-1:0] shreg_q, shreg_d;
   logic [4:0]                bit_cnt_q, bit_cnt_d;
   logic [7:0]                hold_cnt_q, hold_cnt_d;
   logic [SEL_W-1:0]          des_sel_q, des_sel_d;
   logic                      hold_q, hold_d;
   logic                      sync_q, sync_d;
   logic                      swr_q, swr_d;
   logic                      ok_q, ok_d;
   logic                      err_q, err_d;
   logic                      busy_q, busy_d;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         shreg_q    <= '0;
         bit_cnt_q  <= '0;
         hold_cnt_q <= '0;
         des_sel_q  <= SEL_W'(RESET_SEL);
         hold_q     <= 1'b1;
         sync_q     <= 1'b1;
         swr_q      <= 1'b0;
         ok_q       <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         bit_cnt_q  <= bit_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         des_sel_q  <= des_sel_d;
         hold_q     <= hold_d;
         sync_q     <= sync_d;
         swr_q      <= swr_d;
         ok_q       <= ok_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      bit_cnt_d  = bit_cnt_q;
      hold_cnt_d = hold_cnt_q;
      des_sel_d  = des_sel_q;
      hold_d     = hold_q;
      sync_d     = sync_q;
      swr_d      = swr_q;
      ok_d       = 1'b0;
      err_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (csn_fall) begin
               state_d   = SHIFT;
               shreg_d   = '0;
               bit_cnt_d = '0;
            end
         end
         SHIFT: begin
            // A coincident csn rise still takes the final bit before CHECK.
            if (sclk_rise) begin
               shreg_d = {shreg_q[CFG_FRAME_BITS-2:0], sdat_lvl};
               if (bit_cnt_q != CNT_OVF) bit_cnt_d = bit_cnt_q + 5'd1;
            end
            if (csn_rise) state_d = CHECK;
         end
         CHECK: begin
            if (frame_valid(shreg_q, bit_cnt_q)) begin
               des_sel_d  = SEL_W'(shreg_q[SEL_MSB:SEL_LSB]);
               hold_d     = shreg_q[HOLD_BIT];
               sync_d     = shreg_q[SYNC_BIT];
               ok_d       = 1'b1;
               swr_d      = 1'b1;
               hold_cnt_d = HOLD_INIT;
               state_d    = SWITCH;
            end else begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         SWITCH: begin
            if (hold_cnt_q == 8'd1) begin
               swr_d   = 1'b0;
               state_d = IDLE;
            end else begin
               hold_cnt_d = hold_cnt_q - 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   assign des_sel         = des_sel_q;
   assign hold_if_not_sel = hold_q;
   assign sync_inputs     = sync_q;
   assign switch_reset    = swr_q;
   assign cfg_ok          = ok_q;
   assign cfg_err         = err_q;
   assign busy            = busy_q;

endmodule

// File: tb/tb_des_sel_loader.sv
// Randomized bench for des_sel_loader with a frame-level timing model and literal spot checks.
module tb_des_sel_loader;

   localparam int H   = 16;
   localparam int BIG = 1 << 30;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       csn   = 1'b1;
   logic       sclk  = 1'b0;
   logic       sdata = 1'b0;
   logic [5:0] des_sel;
   logic       hold_if_not_sel, sync_inputs, switch_reset, cfg_ok, cfg_err, busy;

   always #5 clock = ~clock;

   des_sel_loader #(.SEL_W(6), .SWITCH_HOLD(H), .RESET_SEL(0)) dut (
      .clock(clock), .reset(reset),
      .cfg_csn_in(csn), .cfg_sclk_in(sclk), .cfg_sdata_in(sdata),
      .des_sel(des_sel), .hold_if_not_sel(hold_if_not_sel), .sync_inputs(sync_inputs),
      .switch_reset(switch_reset), .cfg_ok(cfg_ok), .cfg_err(cfg_err), .busy(busy)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // model: committed values plus cycle windows for pulses and busy/switch intervals
   logic [5:0] m_sel, p_sel;
   logic       m_hold, m_sync, p_hold, p_sync;
   int commit_cyc, ok_cyc, err_cyc, swr_lo, swr_hi, busy_lo, busy_hi;
   int ok_seen, err_seen, swr_seen;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic void model_reset();
      m_sel = 6'd0; m_hold = 1'b1; m_sync = 1'b1;
      commit_cyc = -1; ok_cyc = -1; err_cyc = -1;
      swr_lo = 1; swr_hi = 0; busy_lo = 1; busy_hi = 0;
   endfunction

   function automatic bit model_valid(input logic [15:0] f, input int n);
      return n == 16 && f[15:12] == 4'hA && f[3:0] == (f[15:12] ^ f[11:8] ^ f[7:4]);
   endfunction

   function automatic logic [15:0] make_frame(input logic [5:0] sel, input logic h, input logic s);
      logic [15:0] f;
      f[15:4] = {4'hA, h, s, sel};
      f[3:0]  = f[15:12] ^ f[11:8] ^ f[7:4];
      return f;
   endfunction

   initial begin
      model_reset();
      ok_seen = 0; err_seen = 0; swr_seen = 0;
      forever begin
         @(posedge clock);
         cyc++;
         #1;
         if (cyc == commit_cyc) begin
            m_sel = p_sel; m_hold = p_hold; m_sync = p_sync;
         end
         check("des_sel", des_sel, m_sel);
         check("hold_if_not_sel", hold_if_not_sel, m_hold);
         check("sync_inputs", sync_inputs, m_sync);
         check("cfg_ok", cfg_ok, cyc == ok_cyc);
         check("cfg_err", cfg_err, cyc == err_cyc);
         check("switch_reset", switch_reset, cyc >= swr_lo && cyc <= swr_hi);
         check("busy", busy, cyc >= busy_lo && cyc <= busy_hi);
         ok_seen  += int'(cfg_ok);
         err_seen += int'(cfg_err);
         swr_seen += int'(switch_reset);
      end
   end

   // Pins change on the falling clock edge; the first rising edge to see a change is cyc+1.
   task automatic send_frame(input logic [16:0] bits, input int n, input bit close);
      int  c;
      bit  acc;
      logic [15:0] f;
      @(negedge clock);
      csn = 1'b0;
      c   = cyc;
      acc = !(c + 2 >= busy_lo && c + 2 <= busy_hi);
      if (acc) begin
         busy_lo = c + 3;
         busy_hi = BIG;
      end
      repeat (4) @(negedge clock);
      for (int i = n - 1; i >= 0; i--) begin
         sdata = bits[i];
         repeat (4) @(negedge clock);
         sclk = 1'b1;
         repeat (4) @(negedge clock);
         sclk = 1'b0;
      end
      if (!close) return;
      repeat (4) @(negedge clock);
      csn = 1'b1;
      c   = cyc;
      if (acc) begin
         f = (n == 15) ? {1'b0, bits[14:0]} : bits[15:0];
         if (model_valid(f, n)) begin
            p_sel = f[9:4]; p_hold = f[11]; p_sync = f[10];
            commit_cyc = c + 4; ok_cyc = c + 4;
            swr_lo = c + 4; swr_hi = c + 3 + H;
            busy_hi = c + 3 + H;
         end else begin
            err_cyc = c + 4;
            busy_hi = c + 3;
         end
      end
   endtask

   task automatic gap(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0; csn = 1'b1; sclk = 1'b0;
      model_reset();
      #1;
      check("reset switch_reset", switch_reset, 0);
      check("reset busy", busy, 0);
      check("reset des_sel", des_sel, 0);
      check("reset hold", hold_if_not_sel, 1);
      repeat (3) @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic clr_counts();
      ok_seen = 0; err_seen = 0; swr_seen = 0;
   endtask

   initial begin
      logic [15:0] f;
      logic [16:0] b;
      int          k;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      gap(4);
      check("after reset busy", busy, 0);

      clr_counts();
      send_frame({1'b0, 16'hA856}, 16, 1'b1);
      gap(30);
      check("bad csum err count", err_seen, 1);
      check("bad csum des_sel", des_sel, 0);
      check("bad csum swr", swr_seen, 0);

      send_frame({2'b00, 15'h2857}, 15, 1'b1);
      gap(30);
      send_frame({1'b1, 16'hA857}, 17, 1'b1);
      gap(30);
      send_frame({1'b0, 16'hB856}, 16, 1'b1);
      gap(30);
      check("reject err count", err_seen, 4);
      check("reject ok count", ok_seen, 0);
      check("reject flags", {hold_if_not_sel, sync_inputs}, 3);

      clr_counts();
      send_frame({1'b0, 16'hA857}, 16, 1'b1);
      gap(30);
      check("A857 des_sel", des_sel, 5);
      check("A857 hold", hold_if_not_sel, 1);
      check("A857 sync", sync_inputs, 0);
      check("A857 ok count", ok_seen, 1);
      check("A857 swr cycles", swr_seen, 16);

      clr_counts();
      send_frame({1'b0, 16'hAEAE}, 16, 1'b1);
      gap(5);
      send_frame({1'b0, 16'hA0FF}, 16, 1'b1);
      gap(30);
      check("ignored ok count", ok_seen, 1);
      check("ignored err count", err_seen, 0);
      check("ignored des_sel", des_sel, 42);
      send_frame({1'b0, 16'hA857}, 16, 1'b1);
      gap(30);
      check("after ignore des_sel", des_sel, 5);

      send_frame({1'b0, 16'hAEAE}, 16, 1'b0);
      do_reset();
      gap(6);
      send_frame({1'b0, 16'hA857}, 16, 1'b1);
      gap(30);
      check("post shift reset des_sel", des_sel, 5);

      send_frame({1'b0, 16'hAEAE}, 16, 1'b1);
      gap(8);
      check("mid switch swr", switch_reset, 1);
      do_reset();
      gap(6);
      send_frame({1'b0, 16'hAEAE}, 16, 1'b1);
      gap(30);
      check("post switch reset des_sel", des_sel, 42);

      for (int i = 0; i < 20; i++) begin
         k = $urandom_range(0, 3);
         f = make_frame(6'($urandom), 1'($urandom), 1'($urandom));
         case (k)
            0: send_frame({1'b0, 16'($urandom)}, 16, 1'b1);
            1, 2: send_frame({1'b0, f}, 16, 1'b1);
            default: begin
               b = {1'($urandom), f};
               case ($urandom_range(0, 2))
                  0: send_frame(b, 15, 1'b1);
                  1: send_frame(b, 17, 1'b1);
                  default: send_frame({1'b0, f ^ 16'(1 << $urandom_range(0, 3))}, 16, 1'b1);
               endcase
            end
         endcase
         gap($urandom_range(22, 40));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/des_sel_loader.md
# des_sel_loader

Serial configuration front-end that produces the design-select controls (`des_sel`, `hold_if_not_sel`, `sync_inputs`) consumed by the top-level design multiplexer. It accepts a 3-wire, chip-select-framed serial stream from dedicated pins and checks each frame's magic nibble, length and checksum. Only valid frames are committed. After each commit it raises a quiesce reset of fixed length, so the newly selected design starts from reset with stable inputs.

## Interface
Parameters:
- `SEL_W`, default 6: width of `des_sel`.
- `SWITCH_HOLD`, default 16: number of cycles `switch_reset` stays high after a commit. Legal range 1..255.
- `RESET_SEL`, default 0: value of `des_sel` after reset.

Ports:
- `clock` in 1: single system clock.
- `reset` in 1: asynchronous, active-low.
- `cfg_csn_in` in 1: frame select from pin, active-low, asynchronous to `clock`.
- `cfg_sclk_in` in 1: serial clock from pin; data is sampled on its rising edge.
- `cfg_sdata_in` in 1: serial data from pin, MSB first.
- `des_sel` out SEL_W: committed design index.
- `hold_if_not_sel` out 1: committed flag.
- `sync_inputs` out 1: committed flag.
- `switch_reset` out 1: quiesce reset, ORed into the selected design's reset outside this block.
- `cfg_ok` out 1: one-cycle pulse when a frame is committed.
- `cfg_err` out 1: one-cycle pulse when a frame is rejected.
- `busy` out 1: high in any state other than IDLE.

## Operation
- All three pin inputs pass through 2-FF synchronizers plus one history flop.
- An sclk rising edge is detected when `sync2 & ~sync3`. Synced sdata is sampled on that same cycle.
- Frame layout, 16 bits: [15:12] magic = 4'hA; [11] hold_if_not_sel; [10] sync_inputs; [9:4] des_sel; [3:0] checksum.
- Checksum rule: frame[3:0] must equal frame[15:12] ^ frame[11:8] ^ frame[7:4].
- States:
  - IDLE: a csn falling edge (synced) moves to SHIFT and clears the shift register and the 5-bit bit counter.
  - SHIFT: each sclk edge shifts in one bit and increments the counter, saturating at 17 (17 means overflow). A csn rising edge moves to CHECK.
  - CHECK, one cycle: the frame is valid when count==16, the magic matches and the checksum matches.
    - Valid: load the output registers, pulse `cfg_ok`, load the hold counter with SWITCH_HOLD, go to SWITCH.
    - Invalid: pulse `cfg_err`, leave the outputs unchanged, go to IDLE.
  - SWITCH: `switch_reset`=1. The counter decrements each cycle; at 1 the block goes to IDLE.
- Frames whose csn falling edge occurs outside IDLE are ignored entirely. No error is reported for them. The host must deassert csn and reassert it once `busy`=0.
- Simultaneous sclk edge and csn rising edge in SHIFT: the bit is shifted first, then the state moves to CHECK.
- Reset values: `des_sel`=RESET_SEL, `hold_if_not_sel`=1, `sync_inputs`=1, `switch_reset`=0, `cfg_ok`=0, `cfg_err`=0, `busy`=0, state=IDLE. Synchronizer flops reset to csn=1, sclk=0.
- Reset asserted mid-frame or mid-SWITCH aborts immediately and restores the reset values.

## Timing
- Pin-to-detection latency: 3 `clock` edges.
- `cfg_sclk_in` high and low phases must each last at least 3 `clock` periods. Data must be stable from 1 clock before to 3 clocks after the sclk rising edge.
- csn rising edge detected → CHECK on the next cycle.
- All outputs are registered:
  - `des_sel`, the flags, `cfg_ok`, and `switch_reset` rising change on the cycle after CHECK.
  - `switch_reset` stays high for exactly SWITCH_HOLD cycles.
  - `busy` falls in the same cycle that `switch_reset` falls.
- `cfg_err` asserts on the cycle after CHECK.
- A minimum of one IDLE cycle separates consecutive frames.

## Structure
- Shared package `des_sel_pkg`:
  - state enum `loader_state_t` (IDLE, SHIFT, CHECK, SWITCH);
  - `CFG_MAGIC` = 4'hA;
  - `CFG_FRAME_BITS` = 16;
  - frame field bit positions.
- One sub-module, `pin_sync`: a 2-FF synchronizer with an extra history flop and a rising/falling edge outputs. It is instantiated three times.

## Test plan
- Reset, then shift frame 16'hA857 → after CHECK: `des_sel`=5, `hold_if_not_sel`=1, `sync_inputs`=0, `cfg_ok` high for 1 cycle, `switch_reset` high for exactly 16 cycles, then `busy`=0.
- Frame 16'hA856 (bad checksum) → `cfg_err` pulses once; `des_sel`=0 and both flags stay 1; `switch_reset` never rises.
- 15-bit frame, then a 17-bit frame (each otherwise valid) → `cfg_err` pulses for each; outputs unchanged.
- Magic 4'hB with a consistent checksum (16'hB856) → rejected with `cfg_err`.
- Valid frame 16'hA857, then a second csn fall during SWITCH carrying 16'hA0FF-form data → ignored (no ok, no err); a later frame sent in IDLE commits normally.
- Assert `reset` mid-SHIFT and separately mid-SWITCH → all outputs return immediately to their reset values; the next valid frame commits normally.
